spi_slave_rx: RTL and testbench

- SPI slave endpoint: consumes the sclk/cs/mosi produced by the SPI master clock/shift stage and drives miso back.
- Samples all SPI pins in the system clk domain (oversampled, no sclk-clocked flops).
- Deserialises mosi into parallel words with a one-cycle valid pulse; serialises a preloaded tx word onto miso.
- Supports all four CPOL/CPHA modes, selected per frame.

---
 rtl/spi_slave_rx.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversamples sclk/cs/mosi in the clk domain, deserialises mosi into words
// and serialises a buffered tx word onto miso. Define SPI_LSB_FIRST_EN for LSB-first bit order.
module spi_slave_rx #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              cs_p0, cs_p1, cs_p2;
  logic              mosi_p0, mosi_p1;
  logic              cpol_q, cpha_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              miso_en;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] next_tx;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              active, frame_start, sample_evt, shift_evt, word_done, reload;

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history for sclk and cs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= cs;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise   = sclk_p1 & ~sclk_p2;
  assign sclk_fall   = ~sclk_p1 & sclk_p2;
  assign cs_fall     = ~cs_p1 & cs_p2;
  assign cs_rise     = cs_p1 & ~cs_p2;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign active      = (state_q == ACTIVE);
  assign frame_start = (state_q == IDLE) && cs_fall;
  assign sample_evt  = active && sample_edge;
  assign shift_evt   = active && shift_edge;
  assign word_done   = sample_evt && (bit_cnt == LAST_BIT);
  // A word finishing together with cs release must not consume the holding register
  assign reload      = frame_start || (word_done && !cs_rise);
  assign rx_next     = rx_insert(rx_shift, mosi_p1);
  assign next_tx     = hold_full ? hold_data : DEFAULT_TX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p3: frame control, word completion and tx holding register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bit_cnt   <= '0;
      miso_en   <= 1'b0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) rx_data <= rx_next;

      if (frame_start) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        bit_cnt <= '0;
      end else if (sample_evt) begin
        bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end

      // cpha=1 keeps miso low until the first leading edge of the frame
      if (frame_start)             miso_en <= ~cpha;
      else if (active && cs_rise)  miso_en <= 1'b0;
      else if (shift_evt)          miso_en <= 1'b1;

      if (reload && hold_full)          hold_full <= 1'b0;
      else if (tx_valid && !hold_full)  hold_full <= 1'b1;
    end
  end

  // The first shift edge of each word presents the freshly loaded bit rather than advancing
  always_ff @(posedge clk) begin
    if (sample_evt) rx_shift <= rx_next;
    if (reload)                            tx_shift <= next_tx;
    else if (shift_evt && bit_cnt != '0)   tx_shift <= tx_advance(tx_shift);
    if (tx_valid && !hold_full) hold_data <= tx_data;
  end

  assign tx_ready = ~hold_full;
  assign busy     = active;
  assign miso     = active && miso_en && tx_bit(tx_shift);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a behavioural SPI master drives table-defined frames; received words
// are scored against a queue of expected words, miso is captured by the master and compared.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n, cpol, cpha, sclk, cs, mosi, miso;
  logic       tx_valid, tx_ready, rx_valid, busy;
  logic [7:0] tx_data, rx_data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_sample_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_data[64];
  int         obs_lat[64];
  int         obs_n = 0;
  int         rd_ptr = 0;

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic [3:0] h;
    logic [1:0] nw;
    logic [7:0] w0;
    logic [7:0] w1;
    logic       pre_en;
    logic [7:0] pre_tx;
    logic       mid_en;
    logic [7:0] mid_tx;
    logic       chk_miso;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic [3:0] abort_bits;
  } vec_t;

  vec_t vecs[7];

  spi_slave_rx #(.DATA_W(8), .DEFAULT_TX(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rx_valid && obs_n < 64) begin
      obs_data[obs_n] <= rx_data;
      obs_lat[obs_n]  <= cyc - last_sample_cyc;
      obs_n           <= obs_n + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic pl, input logic ph, input int h, input int nw,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input logic pe, input logic [7:0] pt,
                              input logic me, input logic [7:0] mt,
                              input logic cm, input logic [7:0] e0, input logic [7:0] e1,
                              input int ab);
    vec_t v;
    v.cpol = pl; v.cpha = ph; v.h = 4'(h); v.nw = 2'(nw); v.w0 = w0; v.w1 = w1;
    v.pre_en = pe; v.pre_tx = pt; v.mid_en = me; v.mid_tx = mt;
    v.chk_miso = cm; v.exp0 = e0; v.exp1 = e1; v.abort_bits = 4'(ab);
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h required %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    for (int k = 0; k < 50 && !tx_ready; k++) @(negedge clk);
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_wait: got 0 required 1 within 50 cycles at %0t", $time);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One SPI bit as the master sees it; m is miso captured at the master's sample edge
  task automatic sclk_bit(input logic pol, input logic pha, input int h, input logic b, output logic m);
    if (!pha) begin
      mosi = b;
      repeat (h) @(negedge clk);
      m = miso;
      sclk = ~pol;
      last_sample_cyc = cyc;
      repeat (h) @(negedge clk);
      sclk = pol;
    end else begin
      repeat (h) @(negedge clk);
      sclk = ~pol;
      mosi = b;
      repeat (h) @(negedge clk);
      m = miso;
      sclk = pol;
      last_sample_cyc = cyc;
    end
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rd_ptr < obs_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_valid: got word %02h required no pulse", obs_data[rd_ptr]);
      end else begin
        e = exp_q.pop_front();
        chk8("rx_data", obs_data[rd_ptr], e);
        chk1("rx_latency_3_4", (obs_lat[rd_ptr] >= 3 && obs_lat[rd_ptr] <= 4), 1'b1);
      end
      rd_ptr++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rx_valid: got no pulse required word %02h", e);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] w, cap;
    logic       m, rdy_low;
    int         nb;
    cpol = v.cpol; cpha = v.cpha; sclk = v.cpol; mosi = 1'b0;
    if (v.pre_en) load_tx(v.pre_tx);
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    chk1("busy_in_frame", busy, 1'b1);
    cpol = ~v.cpol;
    cpha = ~v.cpha;
    if (v.mid_en) load_tx(v.mid_tx);
    rdy_low = !tx_ready;
    for (int wi = 0; wi < int'(v.nw); wi++) begin
      w  = (wi == 0) ? v.w0 : v.w1;
      nb = (v.abort_bits != 0) ? int'(v.abort_bits) : 8;
      if (v.abort_bits == 0) exp_q.push_back(w);
      cap = '0;
      for (int i = 0; i < nb; i++) begin
        sclk_bit(v.cpol, v.cpha, int'(v.h), w[7-i], m);
        cap[7-i] = m;
        if (!tx_ready) rdy_low = 1'b1;
      end
      if (v.chk_miso) chk8((wi == 0) ? "miso_word0" : "miso_word1", cap, (wi == 0) ? v.exp0 : v.exp1);
    end
    repeat (int'(v.h)) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    drain();
    chk1("busy_after_cs", busy, 1'b0);
    if (!v.pre_en && !v.mid_en) chk1("tx_ready_stays_1", !rdy_low, 1'b1);
    cpol = v.cpol;
    cpha = v.cpha;
  endtask

  initial begin
    logic [7:0] w;
    logic       m;

    vecs[0] = mk(1, 1, 2, 1, 8'hAA, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0);
    vecs[1] = mk(0, 0, 4, 1, 8'h3E, 8'h00, 1, 8'h5C, 0, 8'h00, 1, 8'h5C, 8'h00, 0);
    vecs[2] = mk(0, 1, 4, 2, 8'hF0, 8'h0F, 1, 8'h12, 1, 8'h34, 1, 8'h12, 8'h34, 0);
    vecs[3] = mk(1, 0, 4, 1, 8'hC3, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 5);
    vecs[4] = mk(1, 0, 4, 1, 8'hC3, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 8'h00, 0);
    vecs[5] = mk(0, 0, 4, 2, 8'h01, 8'h02, 1, 8'h9D, 0, 8'h00, 1, 8'h9D, 8'hA5, 0);
    vecs[6] = mk(1, 1, 5, 1, 8'h5A, 8'h00, 1, 8'h42, 0, 8'h00, 1, 8'h42, 8'h00, 0);

    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk1("reset_miso", miso, 1'b0);
    chk1("reset_tx_ready", tx_ready, 1'b1);
    chk8("reset_rx_data", rx_data, 8'h00);
    chk1("reset_rx_valid", rx_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 7; n++) run_frame(vecs[n]);

    // Last sample edge and cs release arrive together: word completes, holding word survives
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    load_tx(8'h6B);
    w = 8'hD2;
    exp_q.push_back(w);
    for (int i = 0; i < 7; i++) sclk_bit(1'b0, 1'b0, 4, w[7-i], m);
    mosi = w[0];
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    cs = 1'b1;
    last_sample_cyc = cyc;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    drain();
    chk1("collision_busy", busy, 1'b0);
    chk1("collision_hold_kept", tx_ready, 1'b0);
    run_frame(mk(0, 0, 4, 1, 8'h99, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h6B, 8'h00, 0));

    // Asynchronous reset in the middle of a word
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    load_tx(8'h77);
    w = 8'h3C;
    for (int i = 0; i < 4; i++) sclk_bit(1'b0, 1'b0, 4, w[7-i], m);
    #2;
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #1;
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_rx_valid", rx_valid, 1'b0);
    chk1("midreset_tx_ready", tx_ready, 1'b1);
    chk8("midreset_rx_data", rx_data, 8'h00);
    chk1("midreset_miso", miso, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drain();
    run_frame(mk(0, 0, 4, 1, 8'h81, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 8'h00, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
